// File: rtl/timing_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : timing_mode_ctrl
//  Description : Shadow/active video timing register set. Software writes
//                the shadow fields, then commits. A validated commit is
//                applied either immediately (nothing applied yet) or at the
//                next vsync falling edge. A vsync watchdog forces the apply
//                if no frame boundary arrives in time.
//  Options     : TIMING_PRESET_EN - reset both register sets to a
//                640x480@60 timing and mark the active set valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module timing_mode_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cfg_we,
    input  logic [3:0]  i_cfg_addr,
    input  logic [22:0] i_cfg_wdata,
    input  logic        i_cfg_commit,
    input  logic [2:0]  i_sync_in,
    output logic [11:0] o_h_total,
    output logic [11:0] o_h_size,
    output logic [10:0] o_h_sync,
    output logic [10:0] o_h_start,
    output logic [10:0] o_v_total,
    output logic [10:0] o_v_size,
    output logic [9:0]  o_v_sync,
    output logic [9:0]  o_v_start,
    output logic [22:0] o_vs_reset,
    output logic        o_timing_valid,
    output logic        o_busy,
    output logic        o_applied,
    output logic        o_cfg_err,
    output logic        o_timeout
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PENDING = 2'd1;
    localparam logic [1:0] S_APPLY   = 2'd2;

`ifdef TIMING_PRESET_EN
    localparam logic [11:0] C_H_TOTAL_RST  = 12'd800;
    localparam logic [11:0] C_H_SIZE_RST   = 12'd640;
    localparam logic [10:0] C_H_SYNC_RST   = 11'd96;
    localparam logic [10:0] C_H_START_RST  = 11'd144;
    localparam logic [10:0] C_V_TOTAL_RST  = 11'd525;
    localparam logic [10:0] C_V_SIZE_RST   = 11'd480;
    localparam logic [9:0]  C_V_SYNC_RST   = 10'd2;
    localparam logic [9:0]  C_V_START_RST  = 10'd35;
    localparam logic        C_VALID_RST    = 1'b1;
`else
    localparam logic [11:0] C_H_TOTAL_RST  = 12'd0;
    localparam logic [11:0] C_H_SIZE_RST   = 12'd0;
    localparam logic [10:0] C_H_SYNC_RST   = 11'd0;
    localparam logic [10:0] C_H_START_RST  = 11'd0;
    localparam logic [10:0] C_V_TOTAL_RST  = 11'd0;
    localparam logic [10:0] C_V_SIZE_RST   = 11'd0;
    localparam logic [9:0]  C_V_SYNC_RST   = 10'd0;
    localparam logic [9:0]  C_V_START_RST  = 10'd0;
    localparam logic        C_VALID_RST    = 1'b0;
`endif
    localparam logic [22:0] C_VS_RESET_RST = 23'd0;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nx;
    logic        r_vs_q;
    logic [22:0] r_wd;

    // Shadow set
    logic [11:0] r_sh_h_total, r_sh_h_size;
    logic [10:0] r_sh_h_sync, r_sh_h_start, r_sh_v_total, r_sh_v_size;
    logic [9:0]  r_sh_v_sync, r_sh_v_start;
    logic [22:0] r_sh_vs_reset;

    // Shadow set as it will look after this cycle's write
    logic [11:0] w_nx_h_total, w_nx_h_size;
    logic [10:0] w_nx_h_sync, w_nx_h_start, w_nx_v_total, w_nx_v_size;
    logic [9:0]  w_nx_v_sync, w_nx_v_start;
    logic [22:0] w_nx_vs_reset;

    // Active set
    logic [11:0] r_act_h_total, r_act_h_size;
    logic [10:0] r_act_h_sync, r_act_h_start, r_act_v_total, r_act_v_size;
    logic [9:0]  r_act_v_sync, r_act_v_start;
    logic [22:0] r_act_vs_reset;
    logic        r_valid;

    logic        r_cfg_err;
    logic        r_timeout;

    logic        w_idle;
    logic        w_fb;
    logic        w_wr_ok;
    logic        w_cfg_ok;
    logic        w_commit_ok;
    logic        w_reject;
    logic        w_wd_exp;
    logic [12:0] w_h_end;
    logic [11:0] w_v_end;
    logic        w_unused_sync;

    assign w_idle        = (r_state == S_IDLE);
    assign w_fb          = r_vs_q & ~i_sync_in[1];
    assign w_unused_sync = i_sync_in[2] ^ i_sync_in[0];
    assign w_wr_ok       = w_idle && i_cfg_we && (i_cfg_addr <= 4'd8);

    // Merge an accepted write into the shadow view so a same-cycle commit validates the new value
    always_comb begin
        w_nx_h_total  = r_sh_h_total;
        w_nx_h_size   = r_sh_h_size;
        w_nx_h_sync   = r_sh_h_sync;
        w_nx_h_start  = r_sh_h_start;
        w_nx_v_total  = r_sh_v_total;
        w_nx_v_size   = r_sh_v_size;
        w_nx_v_sync   = r_sh_v_sync;
        w_nx_v_start  = r_sh_v_start;
        w_nx_vs_reset = r_sh_vs_reset;
        if (w_wr_ok) begin
            case (i_cfg_addr)
                4'd0:    w_nx_h_total  = i_cfg_wdata[11:0];
                4'd1:    w_nx_h_size   = i_cfg_wdata[11:0];
                4'd2:    w_nx_h_sync   = i_cfg_wdata[10:0];
                4'd3:    w_nx_h_start  = i_cfg_wdata[10:0];
                4'd4:    w_nx_v_total  = i_cfg_wdata[10:0];
                4'd5:    w_nx_v_size   = i_cfg_wdata[10:0];
                4'd6:    w_nx_v_sync   = i_cfg_wdata[9:0];
                4'd7:    w_nx_v_start  = i_cfg_wdata[9:0];
                default: w_nx_vs_reset = i_cfg_wdata;
            endcase
        end
    end

    // Commit validation; sums are widened so large start+size values cannot wrap
    always_comb begin
        w_h_end  = {2'b00, w_nx_h_start} + {1'b0, w_nx_h_size};
        w_v_end  = {2'b00, w_nx_v_start} + {1'b0, w_nx_v_size};
        w_cfg_ok = (w_nx_h_total != 12'd0) && (w_nx_v_total != 11'd0) &&
                   ({1'b0, w_nx_h_sync} < w_nx_h_total) &&
                   ({1'b0, w_nx_v_sync} < w_nx_v_total) &&
                   (w_h_end <= {1'b0, w_nx_h_total}) &&
                   (w_v_end <= {1'b0, w_nx_v_total});
    end

    assign w_commit_ok = w_idle && i_cfg_commit && w_cfg_ok;
    assign w_reject    = (!w_idle && (i_cfg_we || i_cfg_commit)) ||
                         (w_idle && i_cfg_we && (i_cfg_addr > 4'd8)) ||
                         (w_idle && i_cfg_commit && !w_cfg_ok);
    // Counter holds the number of PENDING cycles already elapsed; expire on the last one
    assign w_wd_exp    = (r_state == S_PENDING) && (r_act_vs_reset != 23'd0) &&
                         ((r_wd + 23'd1) == r_act_vs_reset);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_commit_ok) w_state_nx = r_valid ? S_PENDING : S_APPLY;
            end
            S_PENDING: begin
                if (w_fb || w_wd_exp) w_state_nx = S_APPLY;
            end
            S_APPLY:  w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        o_busy    = (r_state == S_PENDING);
        o_applied = (r_state == S_APPLY);
    end

    // Registered vsync for falling-edge detection; resets high so reset release is not a boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_vs_q <= 1'b1;
        else        r_vs_q <= i_sync_in[1];
    end

    // Watchdog counts PENDING cycles and is held at zero elsewhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_wd <= 23'd0;
        else if (r_state == S_PENDING)  r_wd <= r_wd + 23'd1;
        else                            r_wd <= 23'd0;
    end

    // Status pulses; a frame boundary coinciding with expiry is a normal apply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_err <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_cfg_err <= w_reject;
            r_timeout <= w_wd_exp && !w_fb;
        end
    end

    // Shadow set; only accepted IDLE writes change w_nx_*
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_h_total  <= C_H_TOTAL_RST;
            r_sh_h_size   <= C_H_SIZE_RST;
            r_sh_h_sync   <= C_H_SYNC_RST;
            r_sh_h_start  <= C_H_START_RST;
            r_sh_v_total  <= C_V_TOTAL_RST;
            r_sh_v_size   <= C_V_SIZE_RST;
            r_sh_v_sync   <= C_V_SYNC_RST;
            r_sh_v_start  <= C_V_START_RST;
            r_sh_vs_reset <= C_VS_RESET_RST;
        end else begin
            r_sh_h_total  <= w_nx_h_total;
            r_sh_h_size   <= w_nx_h_size;
            r_sh_h_sync   <= w_nx_h_sync;
            r_sh_h_start  <= w_nx_h_start;
            r_sh_v_total  <= w_nx_v_total;
            r_sh_v_size   <= w_nx_v_size;
            r_sh_v_sync   <= w_nx_v_sync;
            r_sh_v_start  <= w_nx_v_start;
            r_sh_vs_reset <= w_nx_vs_reset;
        end
    end

    // Active set loads all fields atomically at the end of the APPLY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_h_total  <= C_H_TOTAL_RST;
            r_act_h_size   <= C_H_SIZE_RST;
            r_act_h_sync   <= C_H_SYNC_RST;
            r_act_h_start  <= C_H_START_RST;
            r_act_v_total  <= C_V_TOTAL_RST;
            r_act_v_size   <= C_V_SIZE_RST;
            r_act_v_sync   <= C_V_SYNC_RST;
            r_act_v_start  <= C_V_START_RST;
            r_act_vs_reset <= C_VS_RESET_RST;
            r_valid        <= C_VALID_RST;
        end else if (r_state == S_APPLY) begin
            r_act_h_total  <= r_sh_h_total;
            r_act_h_size   <= r_sh_h_size;
            r_act_h_sync   <= r_sh_h_sync;
            r_act_h_start  <= r_sh_h_start;
            r_act_v_total  <= r_sh_v_total;
            r_act_v_size   <= r_sh_v_size;
            r_act_v_sync   <= r_sh_v_sync;
            r_act_v_start  <= r_sh_v_start;
            r_act_vs_reset <= r_sh_vs_reset;
            r_valid        <= 1'b1;
        end
    end

    assign o_h_total      = r_act_h_total;
    assign o_h_size       = r_act_h_size;
    assign o_h_sync       = r_act_h_sync;
    assign o_h_start      = r_act_h_start;
    assign o_v_total      = r_act_v_total;
    assign o_v_size       = r_act_v_size;
    assign o_v_sync       = r_act_v_sync;
    assign o_v_start      = r_act_v_start;
    assign o_vs_reset     = r_act_vs_reset;
    assign o_timing_valid = r_valid;
    assign o_cfg_err      = r_cfg_err;
    assign o_timeout      = r_timeout;

endmodule
`default_nettype wire
